// File: rtl/mips_sync_memory.sv
// Word-organised synchronous memory responding on the multi-cycle MIPS memory port.
// Provides programmable read latency, a ready flag and a sticky access-error flag.
module mips_sync_memory #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_write_data,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  output logic [31:0] o_mem_read_data,
  output logic        o_mem_ready,
  output logic        o_mem_err
);

  // state    | meaning
  // S_IDLE   | no read in progress, or read blocked by a write
  // S_WAIT   | latency counter running for the current address
  // S_VALID  | o_mem_read_data holds the word for the current request
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(READ_LATENCY - 1);
  localparam bit         LP_SINGLE   = (READ_LATENCY == 1);

  logic [31:0] r_mem [0:(1 << ADDR_WIDTH) - 1];

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_cnt;
  logic [3:0]            w_next_cnt;
  logic                  w_load;
  logic                  r_prev_read;
  logic [31:0]           r_last_addr;
  logic [31:0]           r_read_data;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] w_word_idx;
  logic                  w_oor;
  logic                  w_misaligned;
  logic                  w_new_req;

  assign w_word_idx   = i_mem_addr[ADDR_WIDTH+1:2];
  assign w_oor        = (i_mem_addr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign w_misaligned = i_mem_addr[1:0] != 2'b00;
  assign w_new_req    = i_mem_read && (!r_prev_read || (i_mem_addr != r_last_addr));

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_load       = 1'b0;
    if (i_mem_write) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_VALID: begin
          if (!i_mem_read && r_state == S_VALID) begin
            w_next_state = S_IDLE;
          end else if (w_new_req) begin
            if (LP_SINGLE) begin
              w_load       = 1'b1;
              w_next_state = S_VALID;
            end else begin
              w_next_cnt   = LP_CNT_LOAD;
              w_next_state = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!i_mem_read) begin
            w_next_state = S_IDLE;
          end else if (w_new_req) begin
            w_next_cnt = LP_CNT_LOAD;
          end else if (r_cnt == 4'd1) begin
            w_load       = 1'b1;
            w_next_state = S_VALID;
          end else begin
            w_next_cnt = r_cnt - 4'd1;
          end
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_mem_ready = (r_state == S_VALID);
  end

  // A write edge clears prev_read so a still-held read restarts afterwards.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt       <= 4'd0;
      r_prev_read <= 1'b0;
      r_last_addr <= 32'd0;
      r_read_data <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_cnt       <= w_next_cnt;
      r_prev_read <= i_mem_read && !i_mem_write;
      r_last_addr <= i_mem_addr;
      if (w_load) r_read_data <= w_oor ? 32'd0 : r_mem[w_word_idx];
      if ((i_mem_read || i_mem_write) && (w_misaligned || w_oor)) r_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_mem_write && !w_oor) r_mem[w_word_idx] <= i_mem_write_data;
  end

  assign o_mem_read_data = r_read_data;
  assign o_mem_err       = r_err;

endmodule
